// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: imem read port, redirect request and decode-side queue handshake.
// master = fetch_unit, slave = imem/decode/redirect environment.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FQ_DEPTH   = 4
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic                  imem_csb0;
    logic                  imem_web0;
    logic [ADDR_WIDTH-1:0] imem_addr0;
    logic [DATA_WIDTH-1:0] imem_din0;
    logic [DATA_WIDTH-1:0] imem_dout0;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic [CW-1:0]         fq_count;

    modport master (
        output imem_csb0, imem_web0, imem_addr0, imem_din0,
        input  imem_dout0,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, fq_count,
        input  inst_ready
    );

    modport slave (
        input  imem_csb0, imem_web0, imem_addr0, imem_din0,
        output imem_dout0,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, fq_count,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC + imem read port + in-order fetch queue; first instruction at head 2 edges after issue.
// Backpressure by credit: issue only when queue entries plus the in-flight request leave room.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FQ_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] dat;
    } fq_entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  req_pending_q, req_pending_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    fq_entry_t             fq_mem [FQ_DEPTH];

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credit_used;

    // A pop in the same cycle is deliberately not credited, keeping issue off the ready path.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, req_pending_q};
    assign issue       = rst_n && !bus.redirect_valid &&
                         (credit_used < (CW+1)'(FQ_DEPTH));
    assign push        = req_pending_q && !bus.redirect_valid;
    assign pop         = (count_q != '0) && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        req_pending_d = req_pending_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (bus.redirect_valid) begin
            // Flush drops the queue and the in-flight response together.
            pc_d          = bus.redirect_pc;
            req_pending_d = 1'b0;
            head_d        = tail_q;
            count_d       = '0;
        end else begin
            req_pending_d = issue;
            if (issue) begin
                pc_d      = pc_q + ADDR_WIDTH'(1);
                pend_pc_d = pc_q;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            req_pending_q <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            req_pending_q <= req_pending_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_mem[tail_q] <= '{pc: pend_pc_q, dat: bus.imem_dout0};
        end
    end

    assign bus.imem_csb0  = !issue;
    assign bus.imem_web0  = 1'b1;
    assign bus.imem_addr0 = pc_q;
    assign bus.imem_din0  = '0;

    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_data  = fq_mem[head_q].dat;
    assign bus.inst_pc    = fq_mem[head_q].pc;
    assign bus.fq_count   = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus an in-order (pc, data) scoreboard.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FQ_DEPTH(4)) bus ();

    fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FQ_DEPTH(4), .RESET_PC(8'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (!bus.imem_csb0) bus.imem_dout0 <= mem[bus.imem_addr0];
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       rv;
        logic [7:0] rpc;
        logic       e_vld;
        logic [7:0] e_pc;
        logic [2:0] e_cnt;
        logic       e_csb;
    } vec_t;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] dat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [7:0] rpc,
                                logic vld, logic [7:0] pc, logic [2:0] cnt, logic csb);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_vld = vld; v.e_pc = pc; v.e_cnt = cnt; v.e_csb = csb;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic sb_reset(logic [7:0] start);
        logic [7:0] p;
        sb.delete();
        p = start;
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{pc: p, dat: mem[p]});
            p = p + 8'd1;
        end
    endtask

    task automatic sb_pop(int row);
        exp_t e;
        if (sb.size() == 0) begin
            chk($sformatf("row%0d sb_empty", row), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d sb_pc", row), {24'd0, bus.inst_pc}, {24'd0, e.pc});
            chk($sformatf("row%0d sb_data", row), bus.inst_data, e.dat);
        end
    endtask

    task automatic apply(vec_t v, int row);
        @(negedge clk);
        rst_n              = v.rst;
        bus.inst_ready     = v.rdy;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        #1;
        chk($sformatf("row%0d vld", row), {31'd0, bus.inst_valid}, {31'd0, v.e_vld});
        chk($sformatf("row%0d cnt", row), {29'd0, bus.fq_count}, {29'd0, v.e_cnt});
        chk($sformatf("row%0d csb", row), {31'd0, bus.imem_csb0}, {31'd0, v.e_csb});
        if (v.e_vld) chk($sformatf("row%0d pc", row), {24'd0, bus.inst_pc}, {24'd0, v.e_pc});
        if (!v.rst)                          sb_reset(8'd0);
        else if (v.rv)                       sb_reset(v.rpc);
        else if (bus.inst_valid && v.rdy)    sb_pop(row);
    endtask

    // A push into a full queue without a matching pop would be an overflow.
    always @(posedge clk) begin
        if (rst_n && dut.count_q == 3'd4 && dut.push && !dut.pop) begin
            errors++;
            $display("FAIL overflow: count %0d with push and no pop", dut.count_q);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[0] = 32'h003100b3; mem[1] = 32'h40208133; mem[2] = 32'h029301b3;
        mem[3] = 32'h003103b3; mem[4] = 32'h00310333;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'd0;
        bus.imem_dout0     = '0;

        // First fetch after reset with decode always ready.
        tbl.push_back(mk(0,1,0,0,   0,0,0,1));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   1,0,1,0));
        tbl.push_back(mk(1,1,0,0,   1,1,1,0));
        tbl.push_back(mk(1,1,0,0,   1,2,1,0));
        tbl.push_back(mk(1,1,0,0,   1,3,1,0));
        tbl.push_back(mk(1,1,0,0,   1,4,1,0));
        // Redirect to 3 while PC 2 is in flight.
        tbl.push_back(mk(0,1,0,0,   0,0,0,1));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   1,0,1,0));
        tbl.push_back(mk(1,1,1,3,   1,1,1,1));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   1,3,1,0));
        tbl.push_back(mk(1,1,0,0,   1,4,1,0));
        // Fill with decode stalled, drain, refill, then redirect to 255 while full.
        tbl.push_back(mk(0,0,0,0,   0,0,0,1));
        tbl.push_back(mk(1,0,0,0,   0,0,0,0));
        tbl.push_back(mk(1,0,0,0,   0,0,0,0));
        tbl.push_back(mk(1,0,0,0,   1,0,1,0));
        tbl.push_back(mk(1,0,0,0,   1,0,2,0));
        tbl.push_back(mk(1,0,0,0,   1,0,3,1));
        tbl.push_back(mk(1,0,0,0,   1,0,4,1));
        tbl.push_back(mk(1,0,0,0,   1,0,4,1));
        tbl.push_back(mk(1,1,0,0,   1,0,4,1));
        tbl.push_back(mk(1,1,0,0,   1,1,3,0));
        tbl.push_back(mk(1,1,0,0,   1,2,2,0));
        tbl.push_back(mk(1,1,0,0,   1,3,2,0));
        tbl.push_back(mk(1,1,0,0,   1,4,2,0));
        tbl.push_back(mk(1,0,0,0,   1,5,2,0));
        tbl.push_back(mk(1,0,0,0,   1,5,3,1));
        tbl.push_back(mk(1,1,1,255, 1,5,4,1));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   0,0,0,0));
        tbl.push_back(mk(1,1,0,0,   1,255,1,0));
        tbl.push_back(mk(1,1,0,0,   1,0,1,0));
        tbl.push_back(mk(1,1,0,0,   1,1,1,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        chk("web0_tied", {31'd0, bus.imem_web0}, 32'd1);
        chk("din0_tied", bus.imem_din0, 32'd0);

        // Asynchronous reset pulse between edges while streaming.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("arst cnt", {29'd0, bus.fq_count}, 32'd0);
        chk("arst csb", {31'd0, bus.imem_csb0}, 32'd1);
        chk("arst pend", {31'd0, dut.req_pending_q}, 32'd0);
        sb_reset(8'd0);
        apply(mk(1,1,0,0, 0,0,0,0), 100);
        apply(mk(1,1,0,0, 0,0,0,0), 101);
        apply(mk(1,1,0,0, 1,0,1,0), 102);
        apply(mk(1,1,0,0, 1,1,1,0), 103);
        apply(mk(1,1,0,0, 1,2,1,0), 104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of decode. Owns the program counter and drives the single-port instruction SRAM (imem) read port. It absorbs the SRAM's one-cycle registered read latency and buffers fetched instructions in a small in-order fetch queue. Decode consumes the queue through a valid/ready handshake. A redirect (branch, jump or flush) retargets the PC and discards everything younger.

## Interface

Parameters:
- ADDR_WIDTH, 8: imem word-address width; the PC is a word address.
- DATA_WIDTH, 32: instruction width.
- FQ_DEPTH, 4: fetch-queue entries; must be a power of two and at least 2.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_csb0  out  1  imem chip select, active low.
- imem_web0  out  1  imem write enable, active low; tied to 1.
- imem_addr0  out  ADDR_WIDTH  imem address; equals the PC.
- imem_din0  out  DATA_WIDTH  imem write data; tied to 0.
- imem_dout0  in  DATA_WIDTH  imem read data.
- redirect_valid  in  1  redirect request.
- redirect_pc  in  ADDR_WIDTH  redirect target word address.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  DATA_WIDTH  head instruction.
- inst_pc  out  ADDR_WIDTH  head PC.
- fq_count  out  clog2(FQ_DEPTH)+1  number of queue entries.

## Operation

- State:
  - pc.
  - req_pending: a request was sampled by imem at the last edge.
  - Circular queue with head and tail pointers plus count, storing data and PC per entry.
- Issue condition: issue = !redirect_valid && (fq_count + req_pending < FQ_DEPTH).
  - A same-cycle pop is not credited.
- Issue outputs: imem_csb0 = !issue, combinational. imem_addr0 = pc.
- On an issue edge:
  - req_pending <= 1.
  - pc <= pc + 1. The addition is modulo 2^ADDR_WIDTH, so 255 wraps to 0.
  - The issued PC is held in pend_pc.
- Capture: at any edge where req_pending = 1 and there is no redirect, push {imem_dout0, pend_pc} at the tail. If there is no issue on that edge, req_pending <= 0.
- Pop: inst_valid = (fq_count != 0). An edge with inst_valid && inst_ready advances the head.
  - Push and pop on the same edge leave fq_count unchanged.
- Redirect edge (redirect_valid = 1):
  - Queue emptied: count = 0 and head = tail.
  - req_pending <= 0, so the in-flight response is dropped and never captured.
  - pc <= redirect_pc.
  - A pop on the same edge is ignored; the flush wins.
- The credit rule guarantees no push into a full queue. Overflow is impossible by construction, and the bench asserts it.

## Timing

- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; req_pending = 0; count = 0; head = tail = 0.
  - inst_valid = 0, fq_count = 0.
  - imem_csb0 = 1 while in reset.
- Request latency: the request is driven in cycle t and sampled by imem at edge t. Data is on imem_dout0 during cycle t+1 and captured at edge t+1. inst_valid is high in cycle t+1 after that edge.
- First fetch after reset release: the first edge issues RESET_PC. RESET_PC appears at the head one edge later, i.e. 2 edges after release.
- Throughput: one instruction per cycle in steady state with inst_ready held at 1.
- Redirect: redirect_valid is high in cycle r, with imem_csb0 = 1 in that cycle. Edge r+1 issues redirect_pc. redirect_pc is at the head after edge r+2.
- Outputs inst_data and inst_pc come from registered storage. There is no combinational path from imem_dout0 to inst_*.

## Test plan

- Reset release, inst_ready = 1, imem words 0..4 = 003100b3, 40208133, 029301b3, 003103b3, 00310333:
  - inst_valid rises 2 edges after release.
  - The bench sees (pc, data) = (0, 003100b3), (1, 40208133), (2, 029301b3), (3, 003103b3), (4, 00310333) on consecutive cycles.
- inst_ready = 0 from reset:
  - fq_count reaches 4 and imem_csb0 stays at 1 afterwards.
  - Then raise inst_ready: PCs 0, 1, 2, 3, 4 are delivered in order, none lost or duplicated.
- Redirect to 3 while streaming, with PC 2 in flight:
  - Queue empties and inst_valid drops the next cycle.
  - The next delivered entry is (3, 003103b3) exactly 2 edges after the redirect edge.
  - No stale PC appears.
- Redirect with the queue full and inst_ready = 1 on the same edge:
  - fq_count goes to 0.
  - No pop is counted and the next entry has PC = redirect_pc.
- Redirect to 255 with ADDR_WIDTH = 8: delivered PCs are 255, 0, 1.
- rst_n pulsed low mid-stream between edges:
  - inst_valid, fq_count and req_pending clear immediately and imem_csb0 goes to 1.
  - After release, fetch restarts at RESET_PC.
